// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte master: FSM state encoding and byte width.
package spi_pkg;
   localparam int SPI_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      WAIT,
      HOLD,
      GAP
   } spi_state_t;
endpackage

// File: rtl/spi_half_tick.sv
// SCK half-period timer: one-cycle tick every CLK_DIV cycles, self-reloading,
// restartable so each FSM state entry begins a fresh half-period.
module spi_half_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int W = $clog2(CLK_DIV + 1);
   localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst || restart || tick)
         cnt <= RELOAD;
      else
         cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: byte accepted when tx_ready (IDLE/WAIT only), rx_valid 17*CLK_DIV later,
// CS_N rises at 18*CLK_DIV after a last byte; SPI_BYTE_MASTER_CS_GAP_EN adds a 2*CLK_DIV CS_N-high gap.
module spi_byte_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic                tx_last,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [SPI_BITS-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic                SCK,
   output logic                MOSI,
   input  logic                MISO,
   output logic                CS_N
);
   localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

   spi_state_t          state;
   logic [SPI_BITS-2:0] tx_sh;
   logic [SPI_BITS-1:0] rx_sh;
   logic [2:0]          bit_cnt;
   logic                last_q;
   logic                tick;
   logic                accept;
`ifdef SPI_BYTE_MASTER_CS_GAP_EN
   logic                gap_half;
`endif

   assign tx_ready = (state == IDLE) || (state == WAIT);
   assign accept   = tx_valid && tx_ready;
   assign busy     = ~CS_N;

   // Transitions out of IDLE/WAIT are the only ones not driven by a tick,
   // so an accept is the only external restart the timer needs.
   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (accept),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         CS_N     <= 1'b1;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         bit_cnt  <= '0;
         last_q   <= 1'b0;
`ifdef SPI_BYTE_MASTER_CS_GAP_EN
         gap_half <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE, WAIT: begin
               if (accept) begin
                  state   <= SETUP;
                  CS_N    <= 1'b0;
                  MOSI    <= tx_data[SPI_BITS-1];
                  tx_sh   <= tx_data[SPI_BITS-2:0];
                  last_q  <= tx_last;
                  bit_cnt <= '0;
               end
            end
            SETUP: begin
               if (tick) begin
                  state <= HIGH;
                  SCK   <= 1'b1;
                  rx_sh <= {rx_sh[SPI_BITS-2:0], MISO};
               end
            end
            HIGH: begin
               if (tick) begin
                  state <= LOW;
                  SCK   <= 1'b0;
                  // After the final bit MOSI keeps bit 0 through WAIT/HOLD.
                  if (bit_cnt != LAST_BIT) begin
                     MOSI  <= tx_sh[SPI_BITS-2];
                     tx_sh <= {tx_sh[SPI_BITS-3:0], 1'b0};
                  end
               end
            end
            LOW: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                     state    <= last_q ? HOLD : WAIT;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     state   <= HIGH;
                     SCK     <= 1'b1;
                     rx_sh   <= {rx_sh[SPI_BITS-2:0], MISO};
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  CS_N <= 1'b1;
`ifdef SPI_BYTE_MASTER_CS_GAP_EN
                  state    <= GAP;
                  gap_half <= 1'b0;
`else
                  state <= IDLE;
`endif
               end
            end
`ifdef SPI_BYTE_MASTER_CS_GAP_EN
            GAP: begin
               if (tick) begin
                  gap_half <= 1'b1;
                  if (gap_half)
                     state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: mode-0 target model on the pins plus a byte scoreboard.
module tb_spi_byte_master;
   localparam int CD = 2;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       SCK;
   logic       MOSI;
   logic       MISO;
   logic       CS_N;

   spi_byte_master #(.CLK_DIV(CD)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .SCK      (SCK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .CS_N     (CS_N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Target response for the k-th completed byte
   function automatic logic [7:0] resp(input int k);
      logic [7:0] kb;
      kb = 8'(k);
      return (k == 0) ? 8'h3C : (kb * 8'd29 + 8'd17);
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Mode-0 SPI target: captures MOSI on SCK rise, shifts MISO on SCK fall
   logic [7:0] tgt_sh  = 8'h00;
   logic [7:0] tgt_cap = 8'h00;
   int         tgt_bits = 0;
   int         tgt_idx  = 0;
   initial MISO = 1'b0;

   always @(negedge CS_N) begin
      tgt_bits = 0;
      tgt_sh   = resp(tgt_idx);
      MISO     = tgt_sh[7];
   end
   always @(posedge CS_N) tgt_bits = 0;
   always @(posedge SCK) tgt_cap = {tgt_cap[6:0], MOSI};
   always @(negedge SCK) begin
      if (CS_N === 1'b0) begin
         tgt_bits++;
         if (tgt_bits == 8) begin
            tgt_bits = 0;
            tgt_idx++;
            tgt_sh = resp(tgt_idx);
         end else begin
            tgt_sh = tgt_sh << 1;
         end
         MISO = tgt_sh[7];
      end
   end

   // Scoreboard and timing monitor
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];
   int  n_push    = 0;
   int  acc_cyc   = 0;
   int  rise_k    = 0;
   int  rxv_cnt   = 0;
   bit  in_abort  = 0;
   bit  rdy_mon   = 0;
   int  rdy_busy  = 0;
   bit  cs_mon    = 0;
   int  cs_hi     = 0;
   bit  gap_mon   = 0;
   int  gap_cnt   = 0;
   logic sck_prev = 1'b0;
   logic cs_prev  = 1'b1;

   always @(negedge clk) begin
      if (SCK === 1'b1 && sck_prev === 1'b0) begin
         chk("sck_rise_cyc", 32'(cyc), 32'(acc_cyc + (2 * rise_k + 1) * CD));
         rise_k++;
      end
      if (CS_N === 1'b1 && cs_prev === 1'b0 && !in_abort)
         chk("cs_rise_cyc", 32'(cyc), 32'(acc_cyc + 18 * CD));
      if (rx_valid === 1'b1) begin
         rxv_cnt++;
         if (exp_rx.size() == 0) begin
            chk("unexp_rx_valid", 32'd1, 32'd0);
         end else begin
            chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            chk("mosi_byte", 32'(tgt_cap), 32'(exp_tx.pop_front()));
            chk("rx_valid_cyc", 32'(cyc), 32'(acc_cyc + 17 * CD));
         end
      end
      if (rdy_mon && busy === 1'b1 && tx_ready === 1'b1) rdy_busy++;
      if (cs_mon && CS_N !== 1'b0) cs_hi++;
      if (gap_mon && busy === 1'b0 && tx_ready === 1'b0) gap_cnt++;
      sck_prev = SCK;
      cs_prev  = CS_N;
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [7:0] d, input logic last, input bit completes, input bit hold);
      int n;
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      if (completes) begin
         exp_tx.push_back(d);
         exp_rx.push_back(resp(n_push));
         n_push++;
      end
      n = 0;
      while (tx_ready !== 1'b1 && n < 60 * CD) begin
         @(negedge clk);
         n++;
      end
      if (tx_ready !== 1'b1) begin
         chk("accept_timeout", 32'd0, 32'd1);
         tx_valid = 1'b0;
         return;
      end
      @(negedge clk);
      acc_cyc = cyc;
      rise_k  = 0;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40 * CD) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   int acc1;
   int r;

   initial begin
      rst      = 1'b1;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_cs_n",     32'(CS_N),     32'd1);
      chk("rst_sck",      32'(SCK),      32'd0);
      chk("rst_mosi",     32'(MOSI),     32'd0);
      chk("rst_rx_data",  32'(rx_data),  32'h00);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);

      // Single last byte 0xA5, target answers 0x3C
      send(8'hA5, 1'b1, 1'b1, 1'b0);
      chk("a5_busy", 32'(busy), 32'd1);
      wait_idle();

      // Two-byte transaction under one CS_N assertion
      rdy_mon  = 1;
      rdy_busy = 0;
      send(8'h01, 1'b0, 1'b1, 1'b0);
      acc1   = acc_cyc;
      cs_hi  = 0;
      cs_mon = 1;
      send(8'hFF, 1'b1, 1'b1, 1'b0);
      cs_mon = 0;
      chk("b2b_accept_cyc", 32'(acc_cyc), 32'(acc1 + 17 * CD + 1));
      chk("b2b_cs_high", 32'(cs_hi), 32'd0);
      wait_idle();
      rdy_mon = 0;
      chk("b2b_ready_busy", 32'(rdy_busy), 32'd1);

      // Reset ten cycles into a byte
      send(8'h55, 1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      in_abort = 1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_cs_n", 32'(CS_N),     32'd1);
      chk("abort_sck",  32'(SCK),      32'd0);
      chk("abort_mosi", 32'(MOSI),     32'd0);
      chk("abort_rxv",  32'(rx_valid), 32'd0);
      chk("abort_busy", 32'(busy),     32'd0);
      r = rxv_cnt;
      repeat (20 * CD) @(negedge clk);
      chk("abort_no_rxv", 32'(rxv_cnt), 32'(r));
      in_abort = 0;
      send(8'h96, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // tx_valid held with changing data: only the accepted byte goes out
      send(8'hC3, 1'b1, 1'b1, 1'b1);
      repeat (17 * CD) begin
         tx_data = 8'($urandom);
         @(negedge clk);
      end
      tx_valid = 1'b0;
      wait_idle();

      // Two single-byte transactions: CS_N-high time between them
      gap_cnt = 0;
      gap_mon = 1;
      send(8'h5A, 1'b1, 1'b1, 1'b0);
      acc1 = acc_cyc;
      send(8'hE7, 1'b1, 1'b1, 1'b0);
`ifdef SPI_BYTE_MASTER_CS_GAP_EN
      chk("gap_accept_cyc", 32'(acc_cyc), 32'(acc1 + 20 * CD + 1));
      chk("gap_not_ready",  32'(gap_cnt), 32'(2 * CD));
`else
      chk("gap_accept_cyc", 32'(acc_cyc), 32'(acc1 + 18 * CD + 1));
      chk("gap_not_ready",  32'(gap_cnt), 32'd0);
`endif
      gap_mon = 0;
      wait_idle();

      chk("sb_rx_empty", 32'(exp_rx.size()), 32'd0);
      chk("sb_tx_empty", 32'(exp_tx.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
